vram_write_arbiter: RTL and testbench
=====================================

Name: vram_write_arbiter

Overview:
- Shares the single write port of the 160x120x3-bit video memory between NUM_REQ pixel-writing clients.
- Round-robin arbitration; one accepted write per clk.
- Built-in clear engine fills the whole frame with one colour on command, locking out clients while it runs.
- Sits between renderers/CPU and the VGA controller write inputs (data_addr, data_in, write_enable), in the 48 MHz write domain.

Parameters:
NUM_REQ, 3, number of requesters (2..4)
FB_PIXELS, 19200, frame size in pixels (160*120); valid addresses 0..FB_PIXELS-1
ADDR_W, 15, pixel address width

Ports:
clk  input  1  write-side clock (48 MHz)
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester write request
req_ready  output  NUM_REQ  per-requester grant; combinational, one-hot or zero
req_addr  input  NUM_REQ*ADDR_W  packed pixel addresses; requester i at bits [i*ADDR_W +: ADDR_W]
req_rgb  input  NUM_REQ*3  packed colours; requester i at bits [i*3 +: 3]
clear_start  input  1  single-cycle pulse: start full-frame fill
clear_rgb  input  3  fill colour, sampled with clear_start
clear_busy  output  1  high while the fill is running
clear_done  output  1  one-cycle pulse after the last fill write
vram_addr  output  ADDR_W  to VGA controller data_addr
vram_rgb  output  3  to VGA controller data_in
vram_we  output  1  to VGA controller write_enable

Behaviour:
- Reset (async assert, sync release):
  - vram_we=0, vram_addr=0, vram_rgb=0.
  - clear_busy=0, clear_done=0.
  - RR pointer=0, state=ARB.
- States: ARB, CLEAR.
- ARB:
  - Winner is the first valid requester scanning ptr, ptr+1, ... mod NUM_REQ.
  - req_ready is one-hot at the winner; all zero if no request is valid.
  - Handshake occurs when req_valid[i] & req_ready[i].
  - On a handshake, next cycle: vram_we=1, vram_addr/vram_rgb = winner's values. Latency is exactly 1 cycle.
  - Pointer moves to winner+1 mod NUM_REQ after each handshake and holds otherwise.
  - No handshake → vram_we=0 next cycle; vram_addr/vram_rgb hold their last values.
  - Out-of-range address (>=FB_PIXELS): the request is still accepted (ready=1), but the write is dropped (vram_we=0). The pointer still advances.
- clear_start in ARB:
  - All req_ready=0 that cycle; clear_start has priority over requests.
  - clear_rgb is latched.
  - Next state is CLEAR; clear_busy=1 from the next cycle.
- CLEAR:
  - One write per cycle, vram_we=1, vram_rgb=latched colour.
  - vram_addr runs 0,1,...,FB_PIXELS-1 on consecutive cycles (FB_PIXELS cycles total).
  - All req_ready=0; clients stall while holding valid.
  - clear_start is ignored.
  - The cycle after the last write (addr FB_PIXELS-1): clear_done=1 for one cycle, clear_busy=0, vram_we=0, state=ARB.
  - Arbitration resumes in that same cycle. The RR pointer is unchanged by the clear.
- Internal fill counter: ADDR_W bits; no wrap past FB_PIXELS-1.
- Reset mid-clear: the fill aborts immediately, all outputs take reset values, and no clear_done is issued.
- req_ready depends only on state, pointer, req_valid and clear_start. It has no combinational path from req_addr/req_rgb.

Test Plan:
- Single write: reset, then req_valid[1]=1 with addr=100, rgb=3'b101 for one cycle → req_ready[1]=1 that cycle; the next cycle shows vram_we=1, vram_addr=100, vram_rgb=5; vram_we=0 after that.
- Fairness: all three valid continuously for 6 cycles from ptr=0 → grant order 0,1,2,0,1,2; each write appears on vram_* one cycle after its grant.
- Out-of-range: req 0 addr=19200 → req_ready[0]=1, no vram_we pulse; the next grant goes to requester 1 when it is valid.
- Clear: clear_start with clear_rgb=3'b010 → exactly 19200 consecutive vram_we cycles, addr 0..19199, rgb=2. Then one clear_done pulse; clear_busy is high throughout the fill; requests held valid see req_ready=0 until the done cycle.
- Collision: clear_start in the same cycle as req_valid=3'b111 → no grants that cycle, the fill starts next cycle, and the stalled requests complete after clear_done in RR order starting at the unchanged pointer.
- Reset mid-clear: assert rst_n=0 at fill addr 5000 → vram_we=0 and clear_busy=0 immediately; after release the state is ARB with no clear_done.

Source files
------------

// File: rtl/vram_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_write_arbiter
// Purpose  : Round-robin arbiter sharing the single video-memory write port
//            between NUM_REQ pixel writers, with a built-in full-frame clear
//            engine that locks clients out while it fills the frame.
// Revision : 1.0 - initial release
// ============================================================================
module vram_write_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int FB_PIXELS = 19200,
  parameter int ADDR_W    = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*3-1:0]      req_rgb,
  input  logic                      clear_start,
  input  logic [2:0]                clear_rgb,
  output logic                      clear_busy,
  output logic                      clear_done,
  output logic [ADDR_W-1:0]         vram_addr,
  output logic [2:0]                vram_rgb,
  output logic                      vram_we
);

  localparam int              PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]  C_NUM_REQ  = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] C_PTR_MAX = PTR_W'(NUM_REQ-1);
  localparam logic [ADDR_W-1:0] C_LAST_PIX = ADDR_W'(FB_PIXELS-1);

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PTR_W-1:0]    r_ptr;
  logic [ADDR_W-1:0]   r_fill_cnt;

  logic                w_any;
  logic [PTR_W-1:0]    w_win;
  logic [PTR_W:0]      w_scan;
  logic                w_grant;
  logic [PTR_W-1:0]    w_ptr_nxt;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [2:0]          w_win_rgb;
  logic                w_in_range;
  logic                w_fill_last;

  logic [ADDR_W-1:0]   w_addr_arr [NUM_REQ];
  logic [2:0]          w_rgb_arr  [NUM_REQ];

  // Split the packed client buses into per-requester fields
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign w_rgb_arr[g]  = req_rgb[g*3 +: 3];
  end

  // Round-robin scan: first valid requester starting at the pointer
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_scan = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_scan >= C_NUM_REQ) begin
        w_scan = w_scan - C_NUM_REQ;
      end
      if (!w_any && req_valid[w_scan[PTR_W-1:0]]) begin
        w_any = 1'b1;
        w_win = w_scan[PTR_W-1:0];
      end
    end
  end

  // A clear request pre-empts any grant in the same cycle
  assign w_grant     = (r_state == ARB) && !clear_start && w_any;
  assign w_ptr_nxt   = (w_win == C_PTR_MAX) ? '0 : w_win + 1'b1;
  assign w_win_addr  = w_addr_arr[w_win];
  assign w_win_rgb   = w_rgb_arr[w_win];
  assign w_in_range  = (w_win_addr <= C_LAST_PIX);
  assign w_fill_last = (r_fill_cnt == C_LAST_PIX);

  // One-hot grant; depends only on state, pointer, valids and clear_start
  always_comb begin
    req_ready = '0;
    if (w_grant) begin
      req_ready[w_win] = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: leave CLEAR once the last pixel has been written
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB:     if (clear_start) w_state_nxt = CLEAR;
      CLEAR:   if (w_fill_last) w_state_nxt = ARB;
      default: w_state_nxt = ARB;
    endcase
  end

  // Write-port datapath, round-robin pointer and fill counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_fill_cnt <= '0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_rgb   <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (r_state)
        ARB: begin
          if (clear_start) begin
            // First fill write goes out on the cycle busy rises;
            // vram_rgb holds the latched fill colour for the whole fill
            r_fill_cnt <= '0;
            clear_busy <= 1'b1;
            vram_we    <= 1'b1;
            vram_addr  <= '0;
            vram_rgb   <= clear_rgb;
          end else if (w_any) begin
            r_ptr <= w_ptr_nxt;
            if (w_in_range) begin
              vram_we   <= 1'b1;
              vram_addr <= w_win_addr;
              vram_rgb  <= w_win_rgb;
            end else begin
              // Accepted but dropped: address/colour keep their last values
              vram_we <= 1'b0;
            end
          end else begin
            vram_we <= 1'b0;
          end
        end
        CLEAR: begin
          if (w_fill_last) begin
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
            vram_we    <= 1'b0;
          end else begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
            vram_addr  <= r_fill_cnt + 1'b1;
            vram_we    <= 1'b1;
          end
        end
        default: begin
          vram_we <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vram_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_write_arbiter
// Purpose  : Self-checking bench for vram_write_arbiter: table of arbitration
//            vectors with a write scoreboard, plus clear/collision/reset runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_write_arbiter;

  localparam int NR = 3;
  localparam int FB = 19200;
  localparam int AW = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*3-1:0] req_rgb = '0;
  logic            clear_start = 1'b0;
  logic [2:0]      clear_rgb = '0;
  logic            clear_busy;
  logic            clear_done;
  logic [AW-1:0]   vram_addr;
  logic [2:0]      vram_rgb;
  logic            vram_we;

  vram_write_arbiter #(.NUM_REQ(NR), .FB_PIXELS(FB), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_rgb(req_rgb),
    .clear_start(clear_start), .clear_rgb(clear_rgb),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .vram_addr(vram_addr), .vram_rgb(vram_rgb), .vram_we(vram_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    valid;
    logic [AW-1:0] a0, a1, a2;
    logic [2:0]    c0, c1, c2;
    logic [2:0]    rdy;
    logic          we;
  } vec_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [2:0]    rgb;
  } exp_t;

  vec_t          vecs [14];
  exp_t          sb [$];
  int            pass_cnt = 0;
  int            total_cnt = 0;
  logic [AW-1:0] last_addr = '0;
  logic [2:0]    last_rgb = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Expected vram_* contents one cycle after the current cycle
  task automatic push_grant(input logic we, input logic [AW-1:0] a, input logic [2:0] c);
    exp_t e;
    if (we) begin
      e = '{we: 1'b1, addr: a, rgb: c};
      last_addr = a;
      last_rgb  = c;
    end else begin
      e = '{we: 1'b0, addr: last_addr, rgb: last_rgb};
    end
    sb.push_back(e);
  endtask

  // Advance one clock and compare the registered outputs against the scoreboard
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("vram_we", 32'(vram_we), 32'(e.we));
      chk("vram_addr", 32'(vram_addr), 32'(e.addr));
      chk("vram_rgb", 32'(vram_rgb), 32'(e.rgb));
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [AW-1:0] a0, a1, a2,
                       input logic [2:0] c0, c1, c2);
    req_valid = v;
    req_addr  = {a2, a1, a0};
    req_rgb   = {c2, c1, c0};
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [AW-1:0] wa;
    logic [2:0]    wc;

    // Starting from ptr=0: fairness, single write, out-of-range drop, RR wrap
    for (int r = 0; r < 6; r++)
      vecs[r] = '{3'b111, 15'd10, 15'd20, 15'd30, 3'd1, 3'd2, 3'd3, 3'b000, 1'b1};
    vecs[0].rdy = 3'b001; vecs[1].rdy = 3'b010; vecs[2].rdy = 3'b100;
    vecs[3].rdy = 3'b001; vecs[4].rdy = 3'b010; vecs[5].rdy = 3'b100;
    vecs[6]  = '{3'b010, 15'd0,     15'd100, 15'd0,     3'd0, 3'd5, 3'd0, 3'b010, 1'b1};
    vecs[7]  = '{3'b000, 15'd0,     15'd0,   15'd0,     3'd0, 3'd0, 3'd0, 3'b000, 1'b0};
    vecs[8]  = '{3'b001, 15'd19200, 15'd0,   15'd0,     3'd7, 3'd0, 3'd0, 3'b001, 1'b0};
    vecs[9]  = '{3'b011, 15'd1,     15'd200, 15'd0,     3'd1, 3'd6, 3'd0, 3'b010, 1'b1};
    vecs[10] = '{3'b101, 15'd2,     15'd0,   15'd19199, 3'd2, 3'd0, 3'd4, 3'b100, 1'b1};
    vecs[11] = '{3'b110, 15'd0,     15'd300, 15'd33,    3'd0, 3'd3, 3'd5, 3'b010, 1'b1};
    vecs[12] = '{3'b011, 15'd400,   15'd44,  15'd0,     3'd7, 3'd1, 3'd0, 3'b001, 1'b1};
    vecs[13] = '{3'b000, 15'd0,     15'd0,   15'd0,     3'd0, 3'd0, 3'd0, 3'b000, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_we", 32'(vram_we), 0);
    chk("reset_addr", 32'(vram_addr), 0);
    chk("reset_rgb", 32'(vram_rgb), 0);
    chk("reset_busy", 32'(clear_busy), 0);
    chk("reset_done", 32'(clear_done), 0);
    chk("reset_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven arbitration vectors
    for (int r = 0; r < 14; r++) begin
      tick();
      drive(vecs[r].valid, vecs[r].a0, vecs[r].a1, vecs[r].a2,
            vecs[r].c0, vecs[r].c1, vecs[r].c2);
      #1;
      chk($sformatf("ready_row%0d", r), 32'(req_ready), 32'(vecs[r].rdy));
      case (vecs[r].rdy)
        3'b001:  begin wa = vecs[r].a0; wc = vecs[r].c0; end
        3'b010:  begin wa = vecs[r].a1; wc = vecs[r].c1; end
        3'b100:  begin wa = vecs[r].a2; wc = vecs[r].c2; end
        default: begin wa = '0; wc = '0; end
      endcase
      push_grant(vecs[r].we, wa, wc);
    end
    tick();

    // Clear colliding with all three requesters valid (pointer now 1)
    drive(3'b111, 15'd500, 15'd501, 15'd502, 3'd1, 3'd2, 3'd3);
    clear_start = 1'b1;
    clear_rgb   = 3'b010;
    #1;
    chk("collide_ready", 32'(req_ready), 0);
    chk("collide_busy", 32'(clear_busy), 0);
    tick();
    clear_start = 1'b0;
    bad = 0;
    for (int i = 0; i < FB; i++) begin
      if (!(vram_we === 1'b1 && vram_addr === 15'(i) && vram_rgb === 3'd2 &&
            clear_busy === 1'b1 && clear_done === 1'b0 && req_ready === 3'b000)) begin
        if (bad == 0)
          $display("first bad fill cycle %0d: we=%b addr=%0d rgb=%0d busy=%b done=%b ready=%b",
                   i, vram_we, vram_addr, vram_rgb, clear_busy, clear_done, req_ready);
        bad++;
      end
      if (i < FB - 1) tick();
    end
    chk("clear_fill_bad_cycles", bad, 0);
    tick();
    chk("done_pulse", 32'(clear_done), 1);
    chk("done_busy", 32'(clear_busy), 0);
    chk("done_we", 32'(vram_we), 0);
    chk("done_ready", 32'(req_ready), 32'(3'b010));
    push_grant(1'b1, 15'd501, 3'd2);
    tick();
    chk("done_single_cycle", 32'(clear_done), 0);
    chk("post_ready1", 32'(req_ready), 32'(3'b100));
    push_grant(1'b1, 15'd502, 3'd3);
    tick();
    chk("post_ready2", 32'(req_ready), 32'(3'b001));
    push_grant(1'b1, 15'd500, 3'd1);
    tick();
    req_valid = '0;
    #1;
    chk("post_idle_ready", 32'(req_ready), 0);
    push_grant(1'b0, '0, '0);
    tick();

    // Reset in the middle of a fill
    clear_start = 1'b1;
    clear_rgb   = 3'b110;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 6000 && vram_addr !== 15'd5000; i++) tick();
    chk("midclear_reach_5000", 32'(vram_addr), 5000);
    rst_n = 1'b0;
    #1;
    chk("midclear_we", 32'(vram_we), 0);
    chk("midclear_busy", 32'(clear_busy), 0);
    chk("midclear_addr", 32'(vram_addr), 0);
    chk("midclear_rgb", 32'(vram_rgb), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_addr = '0;
    last_rgb  = '0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (clear_done !== 1'b0 || clear_busy !== 1'b0 || vram_we !== 1'b0) bad++;
    end
    chk("after_reset_quiet", bad, 0);
    drive(3'b110, 15'd0, 15'd600, 15'd601, 3'd0, 3'd5, 3'd6);
    #1;
    chk("after_reset_ptr0", 32'(req_ready), 32'(3'b010));
    push_grant(1'b1, 15'd600, 3'd5);
    tick();
    req_valid = '0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
